// File: rtl/cpld_spi_responder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : cpld_spi_responder_pkg                               |
// | Description : Shared constants and types for the DSP-facing SPI    |
// |               responder: register addresses, frame geometry and    |
// |               frame-state encoding.                                |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
package cpld_spi_responder_pkg;

  // Register map (7-bit address space)
  localparam logic [6:0] ADDR_ID      = 7'h00;
  localparam logic [6:0] ADDR_STATUS  = 7'h01;
  localparam logic [6:0] ADDR_CTRL    = 7'h02;
  localparam logic [6:0] ADDR_SCRATCH = 7'h03;

  // Frame geometry: 8 command bits (RnW + address) then 8 data bits
  localparam int unsigned FRAME_LEN = 16;
  localparam int unsigned CMD_LEN   = 8;
  localparam int unsigned CNT_W     = 5;

  // Counter values seen on the rising edge that completes each phase
  localparam logic [CNT_W-1:0] CNT_CMD_LAST   = CNT_W'(CMD_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_FRAME_LAST = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage : cpld_spi_responder_pkg
`default_nettype wire

// File: rtl/cpld_spi_responder_spi_sync.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : cpld_spi_responder_spi_sync                          |
// | Description : 2-flop synchronizer with registered rise/fall edge   |
// |               pulses. Edge pulses appear 3 clk cycles after the    |
// |               pin transition.                                      |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module cpld_spi_responder_spi_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_rise;
  logic r_fall;

  // Synchronize the pin, then compare against the previous synchronized value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
      r_prev <= RESET_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_rise <= r_sync & ~r_prev;
      r_fall <= ~r_sync & r_prev;
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule : cpld_spi_responder_spi_sync
`default_nettype wire

// File: rtl/cpld_spi_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : cpld_spi_responder                                   |
// | Description : Oversampling SPI mode-0 responder giving the DSP     |
// |               read access to ID/status and read/write access to    |
// |               the control and scratch registers.                   |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module cpld_spi_responder
  import cpld_spi_responder_pkg::*;
#(
  parameter logic [7:0] ID_VALUE   = 8'hA5,
  parameter logic [7:0] CTRL_RESET = 8'h00
) (
  input  logic       sysclk,
  input  logic       reset_INV,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  input  logic       spi_cs_INV,
  output logic       spi_miso,
  input  logic [7:0] status,
  output logic [7:0] ctrl,
  output logic       ctrl_wr
);

  logic             w_sck_rise;
  logic             w_sck_fall;
  logic             w_cs_rise;
  logic             w_cs_fall;

  logic             r_mosi_meta;
  logic             r_mosi_s2;
  logic [7:0]       r_status_meta;
  logic [7:0]       r_status_s2;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_shift;
  logic [7:0]       r_tx;
  logic             r_rnw;
  logic [6:0]       r_addr;
  logic             r_miso;
  logic [7:0]       r_ctrl;
  logic             r_ctrl_wr;
  logic [7:0]       r_scratch;

  logic [7:0]       w_cmd;
  logic [7:0]       w_wdata;
  logic [7:0]       w_rd_data;

  // SPI clock idles low (mode 0); chip select idles high
  cpld_spi_responder_spi_sync #(.RESET_VAL(1'b0)) u_sync_sck (
    .clk    (sysclk),
    .rst_n  (reset_INV),
    .i_d    (spi_clk),
    .o_rise (w_sck_rise),
    .o_fall (w_sck_fall)
  );

  cpld_spi_responder_spi_sync #(.RESET_VAL(1'b1)) u_sync_cs (
    .clk    (sysclk),
    .rst_n  (reset_INV),
    .i_d    (spi_cs_INV),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  // Plain 2-flop synchronizers for data in and board status
  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      r_mosi_meta   <= 1'b0;
      r_mosi_s2     <= 1'b0;
      r_status_meta <= 8'h00;
      r_status_s2   <= 8'h00;
    end else begin
      r_mosi_meta   <= spi_mosi;
      r_mosi_s2     <= r_mosi_meta;
      r_status_meta <= status;
      r_status_s2   <= r_status_meta;
    end
  end

  // Byte completed by the current rising edge (shift register plus incoming bit)
  assign w_cmd   = {r_shift[6:0], r_mosi_s2};
  assign w_wdata = {r_shift[6:0], r_mosi_s2};

  // Read mux, addressed by the command byte as it completes
  always_comb begin
    w_rd_data = 8'h00;
    case (w_cmd[6:0])
      ADDR_ID:      w_rd_data = ID_VALUE;
      ADDR_STATUS:  w_rd_data = r_status_s2;
      ADDR_CTRL:    w_rd_data = r_ctrl;
      ADDR_SCRATCH: w_rd_data = r_scratch;
      default:      w_rd_data = 8'h00;
    endcase
  end

  // Frame FSM with registers; the clock edge is handled before a CS rise so a
  // coincident 16th edge still commits its write
  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_shift   <= 8'h00;
      r_tx      <= 8'h00;
      r_rnw     <= 1'b0;
      r_addr    <= 7'h00;
      r_miso    <= 1'b0;
      r_ctrl    <= CTRL_RESET;
      r_ctrl_wr <= 1'b0;
      r_scratch <= 8'h00;
    end else begin
      r_ctrl_wr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt  <= '0;
          r_miso <= 1'b0;
          if (w_cs_fall) begin
            r_state <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (w_sck_rise) begin
            r_shift <= w_cmd;
            r_cnt   <= r_cnt + 1'b1;
            if (r_cnt == CNT_CMD_LAST) begin
              r_state <= ST_DATA;
              r_rnw   <= w_cmd[7];
              r_addr  <= w_cmd[6:0];
              r_tx    <= w_rd_data;
            end
          end
        end
        ST_DATA: begin
          if (w_sck_fall && r_rnw) begin
            r_miso <= r_tx[7];
            r_tx   <= {r_tx[6:0], 1'b0};
          end
          if (w_sck_rise) begin
            r_shift <= w_wdata;
            r_cnt   <= r_cnt + 1'b1;
            if (r_cnt == CNT_FRAME_LAST) begin
              r_state <= ST_DONE;
              r_miso  <= 1'b0;
              if (!r_rnw) begin
                if (r_addr == ADDR_CTRL) begin
                  r_ctrl    <= w_wdata;
                  r_ctrl_wr <= 1'b1;
                end else if (r_addr == ADDR_SCRATCH) begin
                  r_scratch <= w_wdata;
                end
              end
            end
          end
        end
        ST_DONE: begin
          r_miso <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
      if (w_cs_rise) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_miso  <= 1'b0;
      end
    end
  end

  assign spi_miso = r_miso;
  assign ctrl     = r_ctrl;
  assign ctrl_wr  = r_ctrl_wr;

endmodule : cpld_spi_responder
`default_nettype wire

// File: tb/tb_cpld_spi_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tb_cpld_spi_responder                                |
// | Description : Self-checking bench for the SPI responder. Acts as   |
// |               the DSP SPI initiator; expected read bytes go into a |
// |               queue when a frame is launched and are popped when   |
// |               the frame's MISO bits have been collected.           |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module tb_cpld_spi_responder;

  localparam int HALF = 8;  // sysclk cycles per SPI half period

  logic       sysclk = 1'b0;
  logic       reset_INV;
  logic       spi_clk;
  logic       spi_mosi;
  logic       spi_cs_INV;
  logic       spi_miso;
  logic [7:0] status;
  logic [7:0] ctrl;
  logic       ctrl_wr;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         wr_pulses = 0;
  logic [7:0] ctrl_at_pulse = 8'h00;
  logic [31:0] exp_q[$];

  cpld_spi_responder #(.ID_VALUE(8'hA5), .CTRL_RESET(8'h00)) dut (
    .sysclk     (sysclk),
    .reset_INV  (reset_INV),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .spi_cs_INV (spi_cs_INV),
    .spi_miso   (spi_miso),
    .status     (status),
    .ctrl       (ctrl),
    .ctrl_wr    (ctrl_wr)
  );

  always #5 sysclk = ~sysclk;

  // Count write pulses and remember ctrl in the pulse cycle
  always @(negedge sysclk) begin
    if (ctrl_wr === 1'b1) begin
      wr_pulses++;
      ctrl_at_pulse = ctrl;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  // Drive nbits MSB first; collect MISO just before each rising edge
  task automatic spi_xfer(input logic [31:0] tx, input int nbits, input bit keep_cs,
                          output logic [31:0] rx);
    rx = 32'h0;
    spi_cs_INV = 1'b0;
    wait_cycles(HALF);
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_mosi = tx[i];
      wait_cycles(HALF);
      rx = {rx[30:0], spi_miso};
      spi_clk = 1'b1;
      wait_cycles(HALF);
      spi_clk = 1'b0;
    end
    if (!keep_cs) begin
      wait_cycles(HALF);
      spi_cs_INV = 1'b1;
      spi_mosi   = 1'b0;
      wait_cycles(2 * HALF);
    end
  endtask

  task automatic spi_write(input logic [6:0] addr, input logic [7:0] data);
    logic [31:0] r;
    spi_xfer({16'h0, 1'b0, addr, data}, 16, 1'b0, r);
  endtask

  task automatic spi_read(input logic [6:0] addr, input logic [7:0] expv, output logic [7:0] rd);
    logic [31:0] r;
    exp_q.push_back({24'h0, expv});
    spi_xfer({16'h0, 1'b1, addr, 8'h00}, 16, 1'b0, r);
    rd = r[7:0];
  endtask

  task automatic test_reset;
    logic [7:0]  rd;
    logic [31:0] e;
    reset_INV = 1'b0; spi_clk = 1'b0; spi_mosi = 1'b0; spi_cs_INV = 1'b1; status = 8'h00;
    wait_cycles(5);
    n_checks++; if (ctrl !== 8'h00) begin n_fail++; $display("FAIL reset_ctrl: got %h expected 00", ctrl); end
    n_checks++; if (spi_miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b expected 0", spi_miso); end
    n_checks++; if (ctrl_wr !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl_wr: got %b expected 0", ctrl_wr); end
    reset_INV = 1'b1;
    wait_cycles(10);
    wr_pulses = 0;
    spi_read(7'h00, 8'hA5, rd);
    e = exp_q.pop_front();
    n_checks++; if (rd !== e[7:0]) begin n_fail++; $display("FAIL id_read: got %h expected %h", rd, e[7:0]); end
    n_checks++; if (wr_pulses !== 0) begin n_fail++; $display("FAIL id_no_pulse: got %0d pulses expected 0", wr_pulses); end
  endtask

  task automatic test_write_readback;
    logic [7:0]  rd;
    logic [31:0] e;
    wr_pulses = 0;
    spi_write(7'h02, 8'h3C);
    n_checks++; if (ctrl !== 8'h3C) begin n_fail++; $display("FAIL ctrl_write: got %h expected 3c", ctrl); end
    n_checks++; if (wr_pulses !== 1) begin n_fail++; $display("FAIL ctrl_pulse_count: got %0d expected 1", wr_pulses); end
    n_checks++; if (ctrl_at_pulse !== 8'h3C) begin n_fail++; $display("FAIL ctrl_at_pulse: got %h expected 3c", ctrl_at_pulse); end
    spi_read(7'h02, 8'h3C, rd);
    e = exp_q.pop_front();
    n_checks++; if (rd !== e[7:0]) begin n_fail++; $display("FAIL ctrl_readback: got %h expected %h", rd, e[7:0]); end
    wr_pulses = 0;
    spi_write(7'h03, 8'h5A);
    spi_read(7'h03, 8'h5A, rd);
    e = exp_q.pop_front();
    n_checks++; if (rd !== e[7:0]) begin n_fail++; $display("FAIL scratch_readback: got %h expected %h", rd, e[7:0]); end
    n_checks++; if (ctrl !== 8'h3C) begin n_fail++; $display("FAIL ctrl_after_scratch: got %h expected 3c", ctrl); end
    n_checks++; if (wr_pulses !== 0) begin n_fail++; $display("FAIL scratch_no_pulse: got %0d expected 0", wr_pulses); end
  endtask

  task automatic test_status_and_invalid;
    logic [7:0]  rd;
    logic [31:0] e;
    status = 8'hC3;
    wait_cycles(4);
    spi_read(7'h01, 8'hC3, rd);
    e = exp_q.pop_front();
    n_checks++; if (rd !== e[7:0]) begin n_fail++; $display("FAIL status_read: got %h expected %h", rd, e[7:0]); end
    wr_pulses = 0;
    spi_write(7'h01, 8'hFF);
    n_checks++; if (wr_pulses !== 0) begin n_fail++; $display("FAIL ro_write_pulse: got %0d expected 0", wr_pulses); end
    spi_read(7'h01, 8'hC3, rd);
    e = exp_q.pop_front();
    n_checks++; if (rd !== e[7:0]) begin n_fail++; $display("FAIL status_after_ro_write: got %h expected %h", rd, e[7:0]); end
    spi_read(7'h45, 8'h00, rd);
    e = exp_q.pop_front();
    n_checks++; if (rd !== e[7:0]) begin n_fail++; $display("FAIL unmapped_read: got %h expected %h", rd, e[7:0]); end
    spi_write(7'h7F, 8'h99);
    n_checks++; if (ctrl !== 8'h3C || wr_pulses !== 0) begin
      n_fail++; $display("FAIL unmapped_write: ctrl %h pulses %0d expected 3c and 0", ctrl, wr_pulses);
    end
  endtask

  task automatic test_abort;
    logic [7:0]  rd;
    logic [31:0] r;
    logic [31:0] e;
    wr_pulses = 0;
    spi_xfer(32'h0000_002F, 12, 1'b0, r);  // first 12 bits of write 0x02 = 0xFF
    n_checks++; if (ctrl !== 8'h3C) begin n_fail++; $display("FAIL abort_ctrl: got %h expected 3c", ctrl); end
    n_checks++; if (wr_pulses !== 0) begin n_fail++; $display("FAIL abort_pulse: got %0d expected 0", wr_pulses); end
    spi_read(7'h00, 8'hA5, rd);
    e = exp_q.pop_front();
    n_checks++; if (rd !== e[7:0]) begin n_fail++; $display("FAIL after_abort_read: got %h expected %h", rd, e[7:0]); end
  endtask

  task automatic test_overlong;
    logic [31:0] r;
    logic [31:0] e;
    wr_pulses = 0;
    exp_q.push_back(32'h0);
    spi_xfer({8'h0, 1'b0, 7'h02, 8'h11, 8'hFF}, 24, 1'b0, r);
    e = exp_q.pop_front();
    n_checks++; if (r[23:0] !== e[23:0]) begin n_fail++; $display("FAIL overlong_write_miso: got %h expected %h", r[23:0], e[23:0]); end
    n_checks++; if (ctrl !== 8'h11) begin n_fail++; $display("FAIL overlong_ctrl: got %h expected 11", ctrl); end
    n_checks++; if (wr_pulses !== 1) begin n_fail++; $display("FAIL overlong_pulse: got %0d expected 1", wr_pulses); end
    exp_q.push_back(32'h0000_A500);
    spi_xfer({8'h0, 1'b1, 7'h00, 8'h00, 8'hFF}, 24, 1'b0, r);
    e = exp_q.pop_front();
    n_checks++; if (r[15:0] !== e[15:0]) begin n_fail++; $display("FAIL overlong_read_miso: got %h expected %h", r[15:0], e[15:0]); end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0]  rd;
    logic [31:0] r;
    logic [31:0] e;
    wr_pulses = 0;
    spi_xfer(32'h0000_0009, 10, 1'b1, r);  // first 10 bits of write 0x02 = 0x77
    reset_INV = 1'b0;
    wait_cycles(4);
    n_checks++; if (ctrl !== 8'h00) begin n_fail++; $display("FAIL midreset_ctrl: got %h expected 00", ctrl); end
    spi_cs_INV = 1'b1;
    spi_mosi   = 1'b0;
    wait_cycles(4);
    reset_INV = 1'b1;
    wait_cycles(2 * HALF);
    spi_read(7'h02, 8'h00, rd);
    e = exp_q.pop_front();
    n_checks++; if (rd !== e[7:0]) begin n_fail++; $display("FAIL midreset_ctrl_read: got %h expected %h", rd, e[7:0]); end
    spi_read(7'h03, 8'h00, rd);
    e = exp_q.pop_front();
    n_checks++; if (rd !== e[7:0]) begin n_fail++; $display("FAIL midreset_scratch_read: got %h expected %h", rd, e[7:0]); end
    n_checks++; if (wr_pulses !== 0) begin n_fail++; $display("FAIL midreset_pulse: got %0d expected 0", wr_pulses); end
  endtask

  task automatic test_back_to_back;
    logic [7:0]  rd;
    logic [7:0]  v;
    logic [31:0] e;
    for (int k = 0; k < 4; k++) begin
      v = 8'($urandom_range(0, 255));
      wr_pulses = 0;
      spi_write(7'h02, v);
      spi_write(7'h03, ~v);
      n_checks++; if (ctrl !== v || wr_pulses !== 1) begin
        n_fail++; $display("FAIL b2b_ctrl[%0d]: ctrl %h pulses %0d expected %h and 1", k, ctrl, wr_pulses, v);
      end
      spi_read(7'h03, ~v, rd);
      e = exp_q.pop_front();
      n_checks++; if (rd !== e[7:0]) begin n_fail++; $display("FAIL b2b_scratch[%0d]: got %h expected %h", k, rd, e[7:0]); end
      spi_read(7'h02, v, rd);
      e = exp_q.pop_front();
      n_checks++; if (rd !== e[7:0]) begin n_fail++; $display("FAIL b2b_ctrl_read[%0d]: got %h expected %h", k, rd, e[7:0]); end
    end
  endtask

  initial begin
    test_reset();
    test_write_readback();
    test_status_and_invalid();
    test_abort();
    test_overlong();
    test_reset_mid_frame();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_cpld_spi_responder
`default_nettype wire
